// File: rtl/div_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : div_issue_ctrl                                                |
// | Description : RISC-V DIV/DIVU/REM/REMU sequencer around an unsigned divider. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module div_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic        flush,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_req;
  logic        w_signed;
  logic        w_rem;
  logic        w_div_by_zero;
  logic        w_overflow;
  logic [31:0] w_abs_rs1;
  logic [31:0] w_abs_rs2;
  logic [31:0] w_sel;
  logic        w_neg;
  logic [31:0] w_wait_result;

  assign w_req         = ex_valid & ex_funct3[2] & ~flush;
  assign w_signed      = ~ex_funct3[0];
  assign w_rem         = ex_funct3[1];
  assign w_div_by_zero = (ex_rs2 == 32'd0);
  assign w_overflow    = w_signed & (ex_rs1 == 32'h8000_0000) & (ex_rs2 == 32'hFFFF_FFFF);
  assign w_abs_rs1     = (w_signed & ex_rs1[31]) ? (~ex_rs1 + 32'd1) : ex_rs1;
  assign w_abs_rs2     = (w_signed & ex_rs2[31]) ? (~ex_rs2 + 32'd1) : ex_rs2;

  assign w_sel         = r_rem ? div_remainder : div_quotient;
  assign w_neg         = r_rem ? r_neg_r : r_neg_q;
  assign w_wait_result = w_neg ? (~w_sel + 32'd1) : w_sel;

  assign stall_o       = w_req & (r_state != DONE);
  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dividend   <= 32'd0;
      r_divisor    <= 32'd0;
      r_rem        <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      result_o     <= 32'd0;
      result_valid <= 1'b0;
      div_start    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_div_by_zero) begin
              result_o     <= w_rem ? ex_rs1 : 32'hFFFF_FFFF;
              result_valid <= 1'b1;
              r_state      <= DONE;
            end else if (w_overflow) begin
              result_o     <= w_rem ? 32'd0 : 32'h8000_0000;
              result_valid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_dividend <= w_abs_rs1;
              r_divisor  <= w_abs_rs2;
              r_rem      <= w_rem;
              r_neg_q    <= w_signed & (ex_rs1[31] ^ ex_rs2[31]);
              r_neg_r    <= w_signed & ex_rs1[31];
              div_start  <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A flush that coincides with the handshake still has to drain the divider.
          if (div_ready) begin
            div_start <= 1'b0;
            r_state   <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            div_start <= 1'b0;
            r_state   <= IDLE;
          end
        end
        WAIT: begin
          // A flush landing on the done pulse has nothing left to drain.
          if (flush) begin
            r_state <= div_done ? IDLE : DRAIN;
          end else if (div_done) begin
            result_o     <= w_wait_result;
            result_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DRAIN: begin
          if (div_done) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          div_start    <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_div_issue_ctrl                                             |
// | Description : Directed self-checking bench; the bench plays the divider.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        flush;
  logic        stall_o;
  logic [31:0] result_o;
  logic        result_valid;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .flush(flush), .stall_o(stall_o),
    .result_o(result_o), .result_valid(result_valid), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_ready(div_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Normal-path op; dd/dv are the hand-computed magnitudes the divider must see.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] dd, input logic [31:0] dv,
                       input int rdy_delay, input int lat);
    logic [31:0] q;
    logic [31:0] r;
    q = dd / dv;
    r = dd % dv;
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    #1 check({tag, "_stall"}, stall_o, 32'd1);
    check({tag, "_nostart_idle"}, div_start, 32'd0);
    @(negedge clk);
    for (int i = 0; i <= rdy_delay; i++) begin
      div_ready = (i == rdy_delay);
      check({tag, "_start"}, div_start, 32'd1);
      check({tag, "_dividend"}, div_dividend, dd);
      check({tag, "_divisor"}, div_divisor, dv);
      @(negedge clk);
    end
    div_ready = 1'b0;
    check({tag, "_start_drop"}, div_start, 32'd0);
    for (int i = 1; i < lat; i++) begin
      check({tag, "_wait_valid"}, result_valid, 32'd0);
      check({tag, "_wait_dividend"}, div_dividend, dd);
      @(negedge clk);
    end
    div_done = 1'b1; div_quotient = q; div_remainder = r;
    @(negedge clk);
    div_done = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0; ex_valid = 1'b0;
    check({tag, "_valid"}, result_valid, 32'd1);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp);
    check({tag, "_result"}, result_o, exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, result_valid, 32'd0);
    check({tag, "_hold"}, result_o, exp);
  endtask

  task automatic fast_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    ex_valid = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    #1 check({tag, "_stall"}, stall_o, 32'd1);
    @(negedge clk);
    check({tag, "_valid"}, result_valid, 32'd1);
    check({tag, "_nostart"}, div_start, 32'd0);
    check({tag, "_stall_done"}, stall_o, 32'd0);
    ex_valid = 1'b0;
    finish_op(tag, exp);
    check({tag, "_nostart2"}, div_start, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_funct3 = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
    flush = 1'b0; div_ready = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0; div_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start", div_start, 32'd0);
    check("rst_valid", result_valid, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_stall", stall_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Signed with negative divisor: 7 / -2 = -3 rem 1.
    do_op("div_7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 0, 3);
    finish_op("div_7_m2", 32'hFFFF_FFFD);
    do_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 0, 2);
    finish_op("rem_7_m2", 32'd1);

    do_op("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 0, 4);
    finish_op("divu_big", 32'h7FFF_FFFF);
    do_op("remu_big", F_REMU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 0, 1);
    finish_op("remu_big", 32'd1);

    fast_op("div_by0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    fast_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    fast_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    fast_op("remu_by0", F_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);

    // Flush five cycles into WAIT, then try to issue while draining.
    ex_valid = 1'b1; ex_funct3 = F_DIVU; ex_rs1 = 32'd100; ex_rs2 = 32'd7;
    @(negedge clk);
    div_ready = 1'b1;
    @(negedge clk);
    div_ready = 1'b0; ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("drain_nostart", div_start, 32'd0);
      check("drain_novalid", result_valid, 32'd0);
      @(negedge clk);
    end
    ex_valid = 1'b0;
    div_done = 1'b1; div_quotient = 32'd14; div_remainder = 32'd2;
    @(negedge clk);
    div_done = 1'b0;
    check("drain_discard", result_valid, 32'd0);
    check("drain_nostart_after", div_start, 32'd0);
    do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd100, 32'd7, 0, 2);
    finish_op("divu_100_7", 32'd14);

    // Flush in ISSUE without a handshake: straight back to IDLE.
    ex_valid = 1'b1; ex_funct3 = F_DIV; ex_rs1 = 32'd9; ex_rs2 = 32'd3;
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_issue_stall", stall_o, 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    check("flush_issue_nostart", div_start, 32'd0);
    @(negedge clk);
    check("flush_issue_idle", div_start, 32'd0);
    check("flush_issue_novalid", result_valid, 32'd0);

    // Divider not ready for three cycles: -20 / 3 = -6.
    do_op("div_rdy3", F_DIV, 32'hFFFF_FFEC, 32'd3, 32'd20, 32'd3, 3, 2);
    finish_op("div_rdy3", 32'hFFFF_FFFA);

    // Reset in WAIT abandons the op; a stray done in IDLE is ignored.
    ex_valid = 1'b1; ex_funct3 = F_DIVU; ex_rs1 = 32'd100; ex_rs2 = 32'd7;
    @(negedge clk);
    div_ready = 1'b1;
    @(negedge clk);
    div_ready = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_start", div_start, 32'd0);
    check("rstw_valid", result_valid, 32'd0);
    check("rstw_result", result_o, 32'd0);
    check("rstw_dividend", div_dividend, 32'd0);
    check("rstw_divisor", div_divisor, 32'd0);
    rst = 1'b0;
    div_done = 1'b1; div_quotient = 32'd14; div_remainder = 32'd2;
    @(negedge clk);
    div_done = 1'b0;
    check("stray_done_valid", result_valid, 32'd0);
    check("stray_done_result", result_o, 32'd0);
    do_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 0, 3);
    finish_op("rem_m7_2", 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1: EX-stage instruction valid.
REQ-004 SHALL have port ex_funct3, input, 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 means not a divide.
REQ-005 SHALL have ports ex_rs1 and ex_rs2, input, 32 each: dividend and divisor operands.
REQ-006 SHALL have port flush, input, 1: kill the in-flight EX instruction.
REQ-007 SHALL have port stall_o, output, 1: hold the pipeline.
REQ-008 SHALL have ports result_o, output, 32, and result_valid, output, 1: final RISC-V result.
REQ-009 SHALL have ports div_start, output, 1; div_dividend, output, 32; div_divisor, output, 32: unsigned-divider request.
REQ-010 SHALL have ports div_ready, input, 1; div_quotient, input, 32; div_remainder, input, 32; div_done, input, 1 (done is a one-cycle pulse): unsigned-divider response.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-012 A request is ex_valid & ex_funct3[2] & ~flush, sampled in IDLE only.
REQ-013 Fast path, rs2==0: result_o SHALL be 0xFFFFFFFF for DIV/DIVU and rs1 for REM/REMU; go to DONE; div_start never asserts.
REQ-014 Fast path, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: result_o SHALL be 0x80000000 for DIV and 0 for REM; go to DONE.
REQ-015 Otherwise, IDLE SHALL register operand magnitudes (two's-complement absolute value for signed ops with a negative operand, raw value for unsigned), the op, neg_q = sign(rs1)^sign(rs2) (signed only) and neg_r = sign(rs1) (signed only), then go to ISSUE.
REQ-016 div_dividend and div_divisor SHALL come from registers and stay constant from ISSUE until div_done is observed.
REQ-017 In ISSUE, div_start=1; a handshake occurs when div_start & div_ready in the same cycle; the next state is WAIT.
REQ-018 div_start SHALL be 0 in every other state and SHALL deassert the cycle after the handshake.
REQ-019 In WAIT, on div_done the block SHALL select quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-020 A selected quotient SHALL be negated if neg_q; a selected remainder SHALL be negated if neg_r.
REQ-021 The WAIT result SHALL be registered into result_o, and the next state is DONE.
REQ-022 DONE SHALL last exactly 1 cycle with result_valid=1, then return to IDLE; result_valid=0 in all other states.
REQ-023 stall_o SHALL equal ex_valid & ex_funct3[2] & ~flush & (state!=DONE), combinationally.
REQ-024 Fast-path latency: request in cycle N, result_valid in cycle N+1.
REQ-025 Normal-path latency: div_start in cycle N+1, result_valid the cycle after div_done.
REQ-026 Flush in ISSUE without a handshake: next state IDLE, with no divider activity.
REQ-027 Flush in ISSUE with a handshake in the same cycle, or flush in WAIT: next state DRAIN.
REQ-028 DRAIN SHALL wait for div_done, discard the result, and go to IDLE; a new request is not accepted until IDLE.
REQ-029 Flush in DONE: result_valid still pulses; the consumer discards it.
REQ-030 div_done arriving in IDLE, ISSUE or DONE SHALL be ignored.
REQ-031 result_o SHALL hold its last value outside DONE.

Reset
REQ-032 rst SHALL force state IDLE, div_start=0, result_valid=0, result_o=0, operand registers=0 and sign flags=0 in the next cycle, from any state.
REQ-033 Reset during WAIT SHALL abandon the operation without DRAIN; the divider shares rst.

Verification
REQ-034 DIV rs1=7, rs2=0xFFFFFFFE -> div_dividend=7, div_divisor=2, result_o=0xFFFFFFFD; REM with the same operands -> result_o=1.
REQ-035 DIVU rs1=0xFFFFFFFF, rs2=2 -> result_o=0x7FFFFFFF; REMU -> result_o=1; no sign correction.
REQ-036 DIV rs1=5, rs2=0 -> result_o=0xFFFFFFFF with result_valid one cycle after the request, div_start never high; REM 0x80000000 by 0xFFFFFFFF -> result_o=0, fast path.
REQ-037 DIVU 100/7, flush 5 cycles into WAIT -> DRAIN until div_done, no result_valid; a following DIVU 100/7 -> result_o=14.
REQ-038 div_ready held low for 3 cycles in ISSUE -> div_start held and operands stable, handshake on the 4th cycle, correct result.
REQ-039 rst asserted during WAIT -> IDLE next cycle, all outputs 0; a subsequent REM rs1=0xFFFFFFF9 (-7), rs2=2 -> result_o=0xFFFFFFFF.
